// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for a 64K x 8 asynchronous SRAM.
// Requester A (clockport side) and requester B (Pi side) share one SRAM. Each access
// runs SETUP -> STROBE -> HOLD -> DONE, with a programmable number of cycles per phase.
// Every output is a register, so all strobes are loaded from the next-state decode.
module sram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] sram_a,
  inout  wire  [DATA_W-1:0] sram_d,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int MAX_SB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CYC = (MAX_SB > HOLD_CYC) ? MAX_SB : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Each phase loads its length minus one and leaves when the counter reaches zero.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                gnt_b, gnt_b_nxt;     // 1: the current access belongs to B
  logic                last_b, last_b_nxt;   // 1: B received the most recent grant
  logic                lat_we, lat_we_nxt;
  logic [ADDR_W-1:0]   lat_addr_nxt;
  logic [DATA_W-1:0]   lat_wdata, lat_wdata_nxt;
  logic                pick_b;
  logic                busy_nxt;
  logic                last_strobe;
  logic                drive;

  // The latched address register is sram_a itself, so the address is stable for the whole access.
  assign sram_d      = drive ? lat_wdata : {DATA_W{1'bz}};
  assign pick_b      = b_req && (!a_req || !last_b);
  assign busy_nxt    = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
  assign last_strobe = (state == STROBE) && (cnt == '0);

  // Next-state, phase counter and grant/latch decode.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    gnt_b_nxt     = gnt_b;
    last_b_nxt    = last_b;
    lat_we_nxt    = lat_we;
    lat_addr_nxt  = sram_a;
    lat_wdata_nxt = lat_wdata;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          state_nxt     = SETUP;
          cnt_nxt       = SETUP_LD;
          gnt_b_nxt     = pick_b;
          last_b_nxt    = pick_b;
          lat_we_nxt    = pick_b ? b_we    : a_we;
          lat_addr_nxt  = pick_b ? b_addr  : a_addr;
          lat_wdata_nxt = pick_b ? b_wdata : a_wdata;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant history, address and registered SRAM strobes / requester outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt_b     <= 1'b0;
      last_b    <= 1'b1;
      lat_we    <= 1'b0;
      sram_a    <= '0;
      sram_cs_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      drive     <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gnt_b     <= gnt_b_nxt;
      last_b    <= last_b_nxt;
      lat_we    <= lat_we_nxt;
      sram_a    <= lat_addr_nxt;
      sram_cs_n <= !busy_nxt;
      // WE and OE are decoded from one state and one direction bit, so they cannot overlap.
      sram_we_n <= !((state_nxt == STROBE) && lat_we_nxt);
      sram_oe_n <= !((state_nxt == STROBE) && !lat_we_nxt);
      drive     <= busy_nxt && lat_we_nxt;
      a_ack     <= (state_nxt == DONE) && !gnt_b_nxt;
      b_ack     <= (state_nxt == DONE) && gnt_b_nxt;
      // Read data is captured while OE is still low, on the edge that ends the strobe.
      if (last_strobe && !lat_we && !gnt_b) a_rdata <= sram_d;
      if (last_strobe && !lat_we && gnt_b)  b_rdata <= sram_d;
    end
  end

  // Write data holding register; only meaningful while a write is driving the bus.
  always_ff @(posedge clk) begin
    lat_wdata <= lat_wdata_nxt;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (default timing and 2/3/2 timing), each with
// its own SRAM model and two randomized requesters, checked cycle by cycle against a
// transaction-level schedule model of the arbitration and phase timing rules.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       a_req, a_we, b_req, b_we;
  logic [1:0][15:0] a_addr, b_addr;
  logic [1:0][7:0]  a_wdata, b_wdata;
  wire  [1:0]       a_ack, b_ack, cs_n, we_n, oe_n;
  wire  [1:0][7:0]  a_rdata, b_rdata;
  wire  [1:0][15:0] sram_a;
  wire  [7:0]       sram_d0, sram_d1;

  sram_arbiter u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
    .a_ack(a_ack[0]), .a_rdata(a_rdata[0]),
    .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
    .b_ack(b_ack[0]), .b_rdata(b_rdata[0]),
    .sram_a(sram_a[0]), .sram_d(sram_d0),
    .sram_cs_n(cs_n[0]), .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0])
  );

  sram_arbiter #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
    .a_ack(a_ack[1]), .a_rdata(a_rdata[1]),
    .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
    .b_ack(b_ack[1]), .b_rdata(b_rdata[1]),
    .sram_a(sram_a[1]), .sram_d(sram_d1),
    .sram_cs_n(cs_n[1]), .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1])
  );

  // Asynchronous SRAM models: write while CS and WE are low, drive data while CS and OE are low.
  logic [7:0] mem0 [65536];
  logic [7:0] mem1 [65536];
  always @(posedge clk) if (!cs_n[0] && !we_n[0]) mem0[sram_a[0]] <= sram_d0;
  always @(posedge clk) if (!cs_n[1] && !we_n[1]) mem1[sram_a[1]] <= sram_d1;
  assign sram_d0 = (!cs_n[0] && !oe_n[0]) ? mem0[sram_a[0]] : 8'bz;
  assign sram_d1 = (!cs_n[1] && !oe_n[1]) ? mem1[sram_a[1]] : 8'bz;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int p_s(input int d); return (d == 0) ? 1 : 2; endfunction
  function automatic int p_t(input int d); return (d == 0) ? 2 : 3; endfunction
  function automatic int p_h(input int d); return (d == 0) ? 1 : 2; endfunction

  // Reference model state, per instance.
  int         cyc;
  int         free_at [2];
  int         t0 [2];
  bit         act [2], tb [2], twe [2], last_b [2];
  logic [15:0] taddr [2];
  logic [7:0]  twd [2], trd [2], exp_ra [2], exp_rb [2];
  logic [7:0]  ref_mem [2][65536];
  bit          ref_ok [2][65536];

  // Stimulus state.
  bit stop_gen;
  int issued_a [2], issued_b [2], gap_a [2], gap_b [2];
  int ack_n [2];
  bit prev_b [2];

  task automatic model_reset();
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      free_at[d] = 0; act[d] = 0; last_b[d] = 1'b1;
      exp_ra[d] = 8'h00; exp_rb[d] = 8'h00;
      issued_a[d] = 0; issued_b[d] = 0; gap_a[d] = 0; gap_b[d] = 0;
      ack_n[d] = 0; prev_b[d] = 1'b0;
    end
  endtask

  task automatic check_reset(input string ph);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_cs", ph, d), cs_n[d], 1);
      check($sformatf("%s_d%0d_we", ph, d), we_n[d], 1);
      check($sformatf("%s_d%0d_oe", ph, d), oe_n[d], 1);
      check($sformatf("%s_d%0d_ack", ph, d), {a_ack[d], b_ack[d]}, 0);
      check($sformatf("%s_d%0d_rdata", ph, d), {a_rdata[d], b_rdata[d]}, 0);
      check($sformatf("%s_d%0d_addr", ph, d), sram_a[d], 0);
    end
  endtask

  task automatic gen(input int d, output logic we, output logic [15:0] addr, output logic [7:0] wd);
    addr = 16'($urandom_range(0, 15));
    wd   = 8'($urandom);
    we   = ref_ok[d][addr] ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Grant decision at edge n and expected outputs just after it.
  task automatic model_cycle(input int d, input int n);
    int S, T, H, L, k;
    logic ecs, ewe, eoe, eaa, eab;
    logic [7:0] bus;
    S = p_s(d); T = p_t(d); H = p_h(d); L = S + T + H;
    if (n >= free_at[d] && (a_req[d] || b_req[d])) begin
      tb[d]      = b_req[d] && (!a_req[d] || !last_b[d]);
      last_b[d]  = tb[d];
      t0[d]      = n;
      act[d]     = 1'b1;
      free_at[d] = n + L + 2;
      twe[d]   = tb[d] ? b_we[d]    : a_we[d];
      taddr[d] = tb[d] ? b_addr[d]  : a_addr[d];
      twd[d]   = tb[d] ? b_wdata[d] : a_wdata[d];
      if (twe[d]) begin
        ref_mem[d][taddr[d]] = twd[d];
        ref_ok[d][taddr[d]]  = 1'b1;
      end else begin
        trd[d] = ref_mem[d][taddr[d]];
      end
    end
    ecs = 1; ewe = 1; eoe = 1; eaa = 0; eab = 0;
    bus = (d == 0) ? sram_d0 : sram_d1;
    if (act[d]) begin
      k = n - t0[d];
      if (k < L) ecs = 0;
      if (k >= S && k < S + T) begin
        if (twe[d]) ewe = 0; else eoe = 0;
      end
      if (k == S + T && !twe[d]) begin
        if (tb[d]) exp_rb[d] = trd[d]; else exp_ra[d] = trd[d];
      end
      if (k == L) begin
        if (tb[d]) eab = 1; else eaa = 1;
      end
      if (k < L) check($sformatf("d%0d_addr", d), sram_a[d], taddr[d]);
      if (k < L && twe[d]) check($sformatf("d%0d_wbus", d), bus, twd[d]);
      if (k >= L) act[d] = 1'b0;
    end
    check($sformatf("d%0d_cs", d), cs_n[d], ecs);
    check($sformatf("d%0d_we", d), we_n[d], ewe);
    check($sformatf("d%0d_oe", d), oe_n[d], eoe);
    check($sformatf("d%0d_a_ack", d), a_ack[d], eaa);
    check($sformatf("d%0d_b_ack", d), b_ack[d], eab);
    check($sformatf("d%0d_a_rdata", d), a_rdata[d], exp_ra[d]);
    check($sformatf("d%0d_b_rdata", d), b_rdata[d], exp_rb[d]);
    check($sformatf("d%0d_we_oe_excl", d), !we_n[d] && !oe_n[d], 0);
  endtask

  // Requester behaviour: hold until ack, then back-to-back or idle for a random gap.
  task automatic drive(input int d);
    logic we; logic [15:0] ad; logic [7:0] wd;
    if (a_ack[d] || b_ack[d]) begin
      if (ack_n[d] == 0) check($sformatf("d%0d_first_grant", d), b_ack[d], 0);
      else if (ack_n[d] < 16) check($sformatf("d%0d_alternate", d), b_ack[d], !prev_b[d]);
      prev_b[d] = b_ack[d];
      ack_n[d]++;
    end
    if (a_req[d]) begin
      if (a_ack[d]) begin
        issued_a[d]++;
        if (!stop_gen && (issued_a[d] < 8 || $urandom_range(0, 3) != 0)) begin
          gen(d, we, ad, wd);
          a_we[d] = we; a_addr[d] = ad; a_wdata[d] = wd;
        end else begin
          a_req[d] = 1'b0;
          gap_a[d] = $urandom_range(0, 6);
        end
      end
    end else if (!stop_gen) begin
      if (gap_a[d] > 0) gap_a[d]--;
      else begin
        gen(d, we, ad, wd);
        a_req[d] = 1'b1; a_we[d] = we; a_addr[d] = ad; a_wdata[d] = wd;
      end
    end
    if (b_req[d]) begin
      if (b_ack[d]) begin
        issued_b[d]++;
        if (!stop_gen && (issued_b[d] < 8 || $urandom_range(0, 3) != 0)) begin
          gen(d, we, ad, wd);
          b_we[d] = we; b_addr[d] = ad; b_wdata[d] = wd;
        end else begin
          b_req[d] = 1'b0;
          gap_b[d] = $urandom_range(0, 6);
        end
      end
    end else if (!stop_gen) begin
      if (gap_b[d] > 0) gap_b[d]--;
      else begin
        gen(d, we, ad, wd);
        b_req[d] = 1'b1; b_we[d] = we; b_addr[d] = ad; b_wdata[d] = wd;
      end
    end
  endtask

  task automatic run(input int count);
    repeat (count) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) model_cycle(d, cyc);
      for (int d = 0; d < 2; d++) drive(d);
      cyc++;
    end
  endtask

  initial begin
    logic we; logic [15:0] ad; logic [7:0] wd;
    int waited;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    stop_gen = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");

    // Tie after reset: A writes 0x1234<-0xA5, B reads 0x1234 and must be served second.
    for (int d = 0; d < 2; d++) begin
      a_req[d] = 1'b1; a_we[d] = 1'b1; a_addr[d] = 16'h1234; a_wdata[d] = 8'hA5;
      b_req[d] = 1'b1; b_we[d] = 1'b0; b_addr[d] = 16'h1234; b_wdata[d] = 8'h00;
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(700);
    stop_gen = 1'b1;
    run(40);

    // Asynchronous reset in the middle of a write strobe.
    for (int d = 0; d < 2; d++) begin
      a_req[d] = 1'b1; a_we[d] = 1'b1; a_addr[d] = 16'hFFFF; a_wdata[d] = 8'h5A;
    end
    waited = 0;
    while (we_n[0] !== 1'b0 && waited < 20) begin
      run(1);
      waited++;
    end
    if (we_n[0] !== 1'b0) check("wait_we_low", we_n[0], 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    a_req = '0; b_req = '0;
    @(posedge clk);
    #1;
    check_reset("midrst_hold");

    // After release the FSM must be idle again and A must win the first tie.
    model_reset();
    stop_gen = 1'b0;
    for (int d = 0; d < 2; d++) begin
      gen(d, we, ad, wd);
      a_req[d] = 1'b1; a_we[d] = we; a_addr[d] = ad; a_wdata[d] = wd;
      gen(d, we, ad, wd);
      b_req[d] = 1'b1; b_we[d] = we; b_addr[d] = ad; b_wdata[d] = wd;
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(400);
    stop_gen = 1'b1;
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
